// File: rtl/sm3_expnd_core_if.sv
// sm3_expnd_core_if
//   Bundles the message-word input stream and the expanded-word output
//   stream of the SM3 message expander.
//   Signals:
//     msg_inpt_d_i     [31:0] message word, block word 0 first
//     msg_inpt_vld_i          word valid
//     msg_inpt_lst_i          last-block flag, meaningful with word 15 only
//     msg_inpt_rdy_o          expander can accept a word this cycle
//     expnd_otpt_wj_o  [31:0] W_j
//     expnd_otpt_wjj_o [31:0] W'_j = W_j ^ W_(j+4)
//     expnd_otpt_vld_o        wj/wjj valid (no backpressure)
//     expnd_otpt_lst_o        round 63 of a block flagged last
//   Modports:
//     master - message source / expanded-word consumer side
//     slave  - the expander core
interface sm3_expnd_core_if;
    logic [31:0] msg_inpt_d_i;
    logic        msg_inpt_vld_i;
    logic        msg_inpt_lst_i;
    logic        msg_inpt_rdy_o;
    logic [31:0] expnd_otpt_wj_o;
    logic [31:0] expnd_otpt_wjj_o;
    logic        expnd_otpt_vld_o;
    logic        expnd_otpt_lst_o;

    modport master (
        output msg_inpt_d_i,
        output msg_inpt_vld_i,
        output msg_inpt_lst_i,
        input  msg_inpt_rdy_o,
        input  expnd_otpt_wj_o,
        input  expnd_otpt_wjj_o,
        input  expnd_otpt_vld_o,
        input  expnd_otpt_lst_o
    );

    modport slave (
        input  msg_inpt_d_i,
        input  msg_inpt_vld_i,
        input  msg_inpt_lst_i,
        output msg_inpt_rdy_o,
        output expnd_otpt_wj_o,
        output expnd_otpt_wjj_o,
        output expnd_otpt_vld_o,
        output expnd_otpt_lst_o
    );
endinterface

// File: rtl/sm3_expnd_core.sv
// sm3_expnd_core
//   SM3 message expansion. Collects a 16-word block in LOAD, then streams
//   W_j and W'_j for rounds 0..63 on 64 consecutive cycles in EXPND.
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - sm3_expnd_core_if.slave (message input / expanded output)
module sm3_expnd_core (
    input  logic            clk,
    input  logic            rst,
    sm3_expnd_core_if.slave bus
);

    typedef enum logic {
        LOAD  = 1'b0,
        EXPND = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] win [16];
    logic [31:0] win_nxt [16];
    logic [3:0]  word_cnt, word_cnt_nxt;
    logic [5:0]  rnd, rnd_nxt;
    logic        blk_lst, blk_lst_nxt;
    logic [31:0] wj, wj_nxt;
    logic [31:0] wjj, wjj_nxt;
    logic        vld, vld_nxt;
    logic        rdy;
    logic        accept;
    logic [31:0] p1_in, p1_out, w_new;

    assign rdy    = (state == LOAD);
    assign accept = bus.msg_inpt_vld_i & rdy;

    // Window holds W_j..W_(j+15) with win[0] the oldest word, so the
    // recurrence taps are fixed window positions.
    assign p1_in  = win[0] ^ win[7] ^ {win[13][16:0], win[13][31:17]};
    assign p1_out = p1_in ^ {p1_in[16:0], p1_in[31:17]} ^ {p1_in[8:0], p1_in[31:9]};
    assign w_new  = p1_out ^ {win[3][24:0], win[3][31:25]} ^ win[10];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            word_cnt <= '0;
            rnd      <= '0;
            blk_lst  <= 1'b0;
            wj       <= '0;
            wjj      <= '0;
            vld      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
            rnd      <= rnd_nxt;
            blk_lst  <= blk_lst_nxt;
            wj       <= wj_nxt;
            wjj      <= wjj_nxt;
            vld      <= vld_nxt;
            win      <= win_nxt;
        end
    end

    // Next-state logic. The output registers are loaded from the window
    // as it will be after this edge, so round 0 appears one cycle after
    // word 15 is accepted and round j+1 follows round j with no bubble.
    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        rnd_nxt      = rnd;
        blk_lst_nxt  = blk_lst;
        win_nxt      = win;
        wj_nxt       = wj;
        wjj_nxt      = wjj;
        vld_nxt      = 1'b0;

        case (state)
            LOAD: begin
                if (accept) begin
                    for (int i = 0; i < 15; i++) begin
                        win_nxt[i] = win[i + 1];
                    end
                    win_nxt[15]  = bus.msg_inpt_d_i;
                    word_cnt_nxt = word_cnt + 4'd1;
                    if (word_cnt == 4'd15) begin
                        state_nxt   = EXPND;
                        blk_lst_nxt = bus.msg_inpt_lst_i;
                        rnd_nxt     = '0;
                        vld_nxt     = 1'b1;
                        wj_nxt      = win_nxt[0];
                        wjj_nxt     = win_nxt[0] ^ win_nxt[4];
                    end
                end
            end

            EXPND: begin
                if (rnd == 6'd63) begin
                    state_nxt   = LOAD;
                    rnd_nxt     = '0;
                    blk_lst_nxt = 1'b0;
                end else begin
                    for (int i = 0; i < 15; i++) begin
                        win_nxt[i] = win[i + 1];
                    end
                    win_nxt[15] = w_new;
                    rnd_nxt     = rnd + 6'd1;
                    vld_nxt     = 1'b1;
                    wj_nxt      = win_nxt[0];
                    wjj_nxt     = win_nxt[0] ^ win_nxt[4];
                end
            end

            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    assign bus.msg_inpt_rdy_o   = rdy;
    assign bus.expnd_otpt_wj_o  = wj;
    assign bus.expnd_otpt_wjj_o = wjj;
    assign bus.expnd_otpt_vld_o = vld;
    assign bus.expnd_otpt_lst_o = blk_lst & (rnd == 6'd63) & vld;

endmodule

// File: tb/tb_sm3_expnd_core.sv
// tb_sm3_expnd_core
//   Directed bench for sm3_expnd_core: "abc" block, two-block stream,
//   random input gaps, reset mid-LOAD and mid-EXPND, and a block whose
//   last flag appears only on a non-final word.
module tb_sm3_expnd_core;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sm3_expnd_core_if bus ();

    sm3_expnd_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_w [68];
    logic [31:0] obs_wj [64];
    logic [31:0] obs_wjj [64];
    logic [31:0] abc_blk [16];
    logic [31:0] pat_blk [16];

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rol(x, 15) ^ rol(x, 23);
    endfunction

    // Reference expansion over the whole W array.
    task automatic modelExpand(input logic [31:0] blk [16]);
        for (int j = 0; j < 16; j++) exp_w[j] = blk[j];
        for (int j = 16; j < 68; j++) begin
            exp_w[j] = p1(exp_w[j-16] ^ exp_w[j-9] ^ rol(exp_w[j-3], 15))
                       ^ rol(exp_w[j-13], 7) ^ exp_w[j-6];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Feeds nwords words of blk, with up to gap_max idle cycles before each.
    task automatic applyStimulus(input logic [31:0] blk [16], input int nwords,
                                 input logic lst_last, input logic lst_mid,
                                 input int gap_max);
        for (int i = 0; i < nwords; i++) begin
            int gaps;
            gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int g = 0; g < gaps; g++) begin
                bus.msg_inpt_vld_i = 1'b0;
                bus.msg_inpt_lst_i = 1'b1;
                bus.msg_inpt_d_i   = $urandom;
                checkOutput("gap_vld", {31'd0, bus.expnd_otpt_vld_o}, 32'd0);
                @(negedge clk);
            end
            checkOutput($sformatf("load%0d_rdy", i), {31'd0, bus.msg_inpt_rdy_o}, 32'd1);
            checkOutput($sformatf("load%0d_vld", i), {31'd0, bus.expnd_otpt_vld_o}, 32'd0);
            bus.msg_inpt_vld_i = 1'b1;
            bus.msg_inpt_d_i   = blk[i];
            bus.msg_inpt_lst_i = (i == 15) ? lst_last : ((i == 7) ? lst_mid : 1'b0);
            @(negedge clk);
        end
        bus.msg_inpt_vld_i = 1'b0;
        bus.msg_inpt_lst_i = 1'b0;
    endtask

    // Checks nrounds output rounds against the model; a full 64-round run
    // also checks the cycle after round 63 and the number of lst pulses.
    task automatic collectRounds(input logic [31:0] blk [16], input int nrounds,
                                 input logic exp_lst);
        int lst_seen;
        lst_seen = 0;
        modelExpand(blk);
        for (int j = 0; j < nrounds; j++) begin
            obs_wj[j]  = bus.expnd_otpt_wj_o;
            obs_wjj[j] = bus.expnd_otpt_wjj_o;
            if (bus.expnd_otpt_lst_o) lst_seen++;
            checkOutput($sformatf("r%0d_vld", j), {31'd0, bus.expnd_otpt_vld_o}, 32'd1);
            checkOutput($sformatf("r%0d_rdy", j), {31'd0, bus.msg_inpt_rdy_o}, 32'd0);
            checkOutput($sformatf("r%0d_wj", j), bus.expnd_otpt_wj_o, exp_w[j]);
            checkOutput($sformatf("r%0d_wjj", j), bus.expnd_otpt_wjj_o, exp_w[j] ^ exp_w[j+4]);
            checkOutput($sformatf("r%0d_lst", j), {31'd0, bus.expnd_otpt_lst_o},
                        {31'd0, (exp_lst && j == 63)});
            @(negedge clk);
        end
        if (nrounds == 64) begin
            checkOutput("end_vld", {31'd0, bus.expnd_otpt_vld_o}, 32'd0);
            checkOutput("end_rdy", {31'd0, bus.msg_inpt_rdy_o}, 32'd1);
            checkOutput("end_lst", {31'd0, bus.expnd_otpt_lst_o}, 32'd0);
            checkOutput("end_wj_hold", bus.expnd_otpt_wj_o, exp_w[63]);
            checkOutput("lst_pulses", lst_seen, exp_lst ? 32'd1 : 32'd0);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_rdy"}, {31'd0, bus.msg_inpt_rdy_o}, 32'd1);
        checkOutput({tag, "_vld"}, {31'd0, bus.expnd_otpt_vld_o}, 32'd0);
        checkOutput({tag, "_lst"}, {31'd0, bus.expnd_otpt_lst_o}, 32'd0);
        checkOutput({tag, "_wj"}, bus.expnd_otpt_wj_o, 32'd0);
        checkOutput({tag, "_wjj"}, bus.expnd_otpt_wjj_o, 32'd0);
    endtask

    initial begin
        bus.msg_inpt_d_i   = '0;
        bus.msg_inpt_vld_i = 1'b0;
        bus.msg_inpt_lst_i = 1'b0;

        abc_blk[0] = 32'h61626380;
        for (int i = 1; i < 15; i++) abc_blk[i] = 32'h0;
        abc_blk[15] = 32'h00000018;
        for (int i = 0; i < 16; i++) pat_blk[i] = (32'h01010101 * i) ^ 32'hdeadbeef;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;

        // "abc" block, gap-free, with hand-computed anchor values.
        applyStimulus(abc_blk, 16, 1'b1, 1'b0, 0);
        collectRounds(abc_blk, 64, 1'b1);
        checkOutput("abc_r0_wj", obs_wj[0], 32'h61626380);
        checkOutput("abc_r0_wjj", obs_wjj[0], 32'h61626380);
        checkOutput("abc_r1_wj", obs_wj[1], 32'h00000000);
        checkOutput("abc_r15_wj", obs_wj[15], 32'h00000018);
        checkOutput("abc_r16_wj", obs_wj[16], 32'h9092e200);
        checkOutput("abc_r17_wj", obs_wj[17], 32'h00000000);
        checkOutput("abc_r18_wj", obs_wj[18], 32'h000c0606);

        // Two back-to-back blocks: first not last, second last.
        applyStimulus(pat_blk, 16, 1'b0, 1'b0, 0);
        collectRounds(pat_blk, 64, 1'b0);
        applyStimulus(abc_blk, 16, 1'b1, 1'b0, 0);
        collectRounds(abc_blk, 64, 1'b1);

        // Last flag only on word 7 must be ignored.
        applyStimulus(pat_blk, 16, 1'b0, 1'b1, 0);
        collectRounds(pat_blk, 64, 1'b0);

        // Random valid gaps during LOAD.
        applyStimulus(abc_blk, 16, 1'b1, 1'b0, 3);
        collectRounds(abc_blk, 64, 1'b1);
        applyStimulus(pat_blk, 16, 1'b1, 1'b0, 4);
        collectRounds(pat_blk, 64, 1'b1);

        // Reset at round 30, then a fresh "abc" block.
        applyStimulus(abc_blk, 16, 1'b1, 1'b0, 0);
        collectRounds(abc_blk, 30, 1'b1);
        checkOutput("pre_rst_r30_wj", bus.expnd_otpt_wj_o, exp_w[30]);
        rst = 1'b1;
        @(negedge clk);
        checkResetState("rst_expnd");
        rst = 1'b0;
        applyStimulus(abc_blk, 16, 1'b1, 1'b0, 0);
        collectRounds(abc_blk, 64, 1'b1);
        checkOutput("abc2_r16_wj", obs_wj[16], 32'h9092e200);

        // Reset mid-LOAD with an accept in the same cycle; the partial
        // block must be discarded.
        applyStimulus(pat_blk, 5, 1'b0, 1'b0, 0);
        bus.msg_inpt_vld_i = 1'b1;
        bus.msg_inpt_d_i   = 32'hffffffff;
        rst = 1'b1;
        @(negedge clk);
        bus.msg_inpt_vld_i = 1'b0;
        checkResetState("rst_load");
        rst = 1'b0;
        applyStimulus(abc_blk, 16, 1'b1, 1'b0, 0);
        collectRounds(abc_blk, 64, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
